// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous RAM between requesters r0 and r1.
// One access at a time: writes take 2 cycles (grant, access), reads take 3
// (grant, access, data capture), with a one-cycle rvalid pulse to the owner.
module mem_arbiter #(
   parameter int AW = 9,
   parameter int DW = 16,
   parameter bit RR = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    r0_cmd,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_grant,
   output logic [DW-1:0] r0_rdata,
   output logic          r0_rvalid,
   input  logic [2:0]    r1_cmd,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_grant,
   output logic [DW-1:0] r1_rdata,
   output logic          r1_rvalid,
   output logic [AW-1:0] ram_addr,
   output logic          ram_write,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout,
   output logic          busy
);

   localparam logic [2:0] MREAD  = 3'b010;
   localparam logic [2:0] MWRITE = 3'b100;

   typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

   state_t        state;
   logic          owner_q;     // 0 = r0, 1 = r1 owns the access in flight
   logic          last_grant;  // requester granted most recently (0 = r0, 1 = r1)

   logic          req0, req1;
   logic          win0, win1;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_write;

   // Request decode, arbitration and selection of the winner's request fields.
   always_comb begin
      // NOTE: every signal gets a default first, so no path can infer a latch.
      req0      = (r0_cmd == MREAD) || (r0_cmd == MWRITE);
      req1      = (r1_cmd == MREAD) || (r1_cmd == MWRITE);
      win1      = 1'b0;
      win0      = 1'b0;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      sel_write = (r0_cmd == MWRITE);
      if (state == IDLE) begin
         // On a tie, round-robin hands the slot to whoever did not win last time.
         win1 = req1 && (!req0 || (RR && !last_grant));
         win0 = req0 && !win1;
      end
      if (win1) begin
         sel_addr  = r1_addr;
         sel_wdata = r1_wdata;
         sel_write = (r1_cmd == MWRITE);
      end
   end

   assign r0_grant = win0;
   assign r1_grant = win1;
   assign busy     = (state != IDLE);

   // Access sequencer: launches the granted access and returns read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner_q    <= 1'b0;
         last_grant <= 1'b1;
         ram_addr   <= '0;
         ram_write  <= 1'b0;
         ram_din    <= '0;
         r0_rdata   <= '0;
         r1_rdata   <= '0;
         r0_rvalid  <= 1'b0;
         r1_rvalid  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every term reads the pre-edge value.
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         case (state)
            IDLE: begin
               if (win0 || win1) begin
                  // The RAM port registers double as the latched request.
                  owner_q    <= win1;
                  last_grant <= win1;
                  ram_addr   <= sel_addr;
                  ram_write  <= sel_write;
                  if (sel_write) ram_din <= sel_wdata;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               // ram_write still marks this access as a write.
               ram_write <= 1'b0;
               state     <= ram_write ? IDLE : RDATA;
            end
            RDATA: begin
               if (owner_q) begin
                  r1_rdata  <= ram_dout;
                  r1_rvalid <= 1'b1;
               end else begin
                  r0_rdata  <= ram_dout;
                  r0_rvalid <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
